// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding control for the 5-stage RV32I pipeline: tracks in-flight
// destinations, drives ALU operand forwarding selects and load-use/branch stall/flush.

// Forward select for one ALU operand; M result beats W because it is younger.
module hfc_fwd_sel #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
  output logic [1:0]            sel
);
  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_WB = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic mem_hit, wb_hit;

  // x0 is hardwired zero, so a write to it never produces a forwardable value
  assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs);
  assign wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_rs);

  always_comb begin
    sel = SEL_RF;
    if (mem_hit)     sel = SEL_MEM;
    else if (wb_hit) sel = SEL_WB;
  end
endmodule

module hazard_forward_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_regwrite,
  input  logic                  i_id_is_load,
  input  logic                  i_ex_pc_src,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_flush_d,
  output logic                  o_flush_e,
  output logic [CNT_W-1:0]      o_stall_cnt
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } ex_stage_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } wr_stage_t;

  ex_stage_t        ex_q, ex_d;
  wr_stage_t        mem_q, wb_q;
  logic [CNT_W-1:0] stall_cnt;
  logic             lw_stall;

  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] ex_rs;
  logic [NUM_OPS-1:0][1:0]            fwd_sel;

  // Load in E whose result the D instruction may need; rs2 is matched even if unused
  assign lw_stall = ex_q.is_load && (ex_q.rd != '0) &&
                    ((ex_q.rd == i_id_rs1) || (ex_q.rd == i_id_rs2));

  // A taken branch squashes the D instruction, so a load-use stall on it is moot
  assign o_stall_f = lw_stall && !i_ex_pc_src;
  assign o_stall_d = lw_stall && !i_ex_pc_src;
  assign o_flush_d = i_ex_pc_src;
  assign o_flush_e = lw_stall || i_ex_pc_src;

  always_comb begin
    ex_d = '0;
    if (!o_flush_e) begin
      ex_d.rs1      = i_id_rs1;
      ex_d.rs2      = i_id_rs2;
      ex_d.rd       = i_id_rd;
      ex_d.regwrite = i_id_regwrite;
      ex_d.is_load  = i_id_is_load;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      ex_q           <= ex_d;
      mem_q.rd       <= ex_q.rd;
      mem_q.regwrite <= ex_q.regwrite;
      wb_q           <= mem_q;
      if (o_stall_d && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_rs = {ex_q.rs2, ex_q.rs1};

  hfc_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_sel [NUM_OPS-1:0] (
    .ex_rs        (ex_rs),
    .mem_rd       (mem_q.rd),
    .mem_regwrite (mem_q.regwrite),
    .wb_rd        (wb_q.rd),
    .wb_regwrite  (wb_q.regwrite),
    .sel          (fwd_sel)
  );

  assign o_fwd_a_sel = fwd_sel[0];
  assign o_fwd_b_sel = fwd_sel[1];
  assign o_stall_cnt = stall_cnt;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed + random bench for hazard_forward_ctrl against an instruction-level
// model; a second instance with a 2-bit counter checks saturation.
module tb_hazard_forward_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       rw, ld, pc_src;
  logic [1:0] fa, fb, fa2, fb2;
  logic       sf, sd, fd, fe, sf2, sd2, fd2, fe2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rd(rd),
    .i_id_regwrite(rw), .i_id_is_load(ld), .i_ex_pc_src(pc_src),
    .o_fwd_a_sel(fa), .o_fwd_b_sel(fb), .o_stall_f(sf), .o_stall_d(sd),
    .o_flush_d(fd), .o_flush_e(fe), .o_stall_cnt(cnt));

  hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rd(rd),
    .i_id_regwrite(rw), .i_id_is_load(ld), .i_ex_pc_src(pc_src),
    .o_fwd_a_sel(fa2), .o_fwd_b_sel(fb2), .o_stall_f(sf2), .o_stall_d(sd2),
    .o_flush_d(fd2), .o_flush_e(fe2), .o_stall_cnt(cnt2));

  // Reference: the instructions occupying E, M, W (index 0, 1, 2)
  typedef struct {
    int rs1, rs2, rd;
    bit rw, ld;
  } ins_t;
  ins_t pipe[3];
  int   mcnt;

  function automatic ins_t bubble();
    ins_t b;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.rw = 0; b.ld = 0;
    return b;
  endfunction

  function automatic int writes(ins_t i, int r);
    return (i.rw && i.rd != 0 && i.rd == r) ? 1 : 0;
  endfunction

  function automatic int m_fwd(int r);
    if (writes(pipe[1], r) != 0) return 2;
    if (writes(pipe[2], r) != 0) return 1;
    return 0;
  endfunction

  function automatic bit m_lw();
    return pipe[0].ld && pipe[0].rd != 0 &&
           (pipe[0].rd == int'(rs1) || pipe[0].rd == int'(rs2));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit stall;
    stall = m_lw() && !pc_src;
    chk("fwd_a", 32'(fa), 32'(m_fwd(pipe[0].rs1)));
    chk("fwd_b", 32'(fb), 32'(m_fwd(pipe[0].rs2)));
    chk("stall_f", 32'(sf), 32'(stall));
    chk("stall_d", 32'(sd), 32'(stall));
    chk("flush_d", 32'(fd), 32'(pc_src));
    chk("flush_e", 32'(fe), 32'(m_lw() || pc_src));
    chk("cnt16", 32'(cnt), 32'(mcnt > 65535 ? 65535 : mcnt));
    chk("cnt2", 32'(cnt2), 32'(mcnt > 3 ? 3 : mcnt));
    chk("fwd_a_w2", 32'(fa2), 32'(m_fwd(pipe[0].rs1)));
    chk("stall_d_w2", 32'(sd2), 32'(stall));
  endtask

  // Present one D instruction, settle, compare against the model
  task automatic begin_cyc(bit r, int a, int b, int d, bit w, bit l, bit br);
    rst_n = r; rs1 = 5'(a); rs2 = 5'(b); rd = 5'(d); rw = w; ld = l; pc_src = br;
    #1;
    check_model();
  endtask

  task automatic end_cyc();
    bit lw, stall;
    ins_t nxt;
    lw    = m_lw();
    stall = lw && !pc_src;
    nxt.rs1 = rs1; nxt.rs2 = rs2; nxt.rd = rd; nxt.rw = rw; nxt.ld = ld;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] = bubble();
      mcnt = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (lw || pc_src) ? bubble() : nxt;
      if (stall) mcnt++;
    end
    @(negedge clk);
  endtask

  task automatic step(int a, int b, int d, bit w, bit l);
    begin_cyc(1'b1, a, b, d, w, l, 1'b0);
    end_cyc();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    mcnt = 0;
    rst_n = 0; rs1 = 0; rs2 = 0; rd = 0; rw = 0; ld = 0; pc_src = 0;
    @(negedge clk);
    begin_cyc(1'b0, 0, 0, 0, 0, 0, 0); end_cyc();
    begin_cyc(1'b0, 0, 0, 0, 0, 0, 0); end_cyc();

    // Reset state, with a D instruction that would hazard only against a load in E
    begin_cyc(1'b1, 3, 3, 0, 0, 0, 0);
    chk("rst_fwd_a", 32'(fa), 0); chk("rst_stall", 32'(sd), 0); chk("rst_cnt", 32'(cnt), 0);
    end_cyc();

    // Back-to-back: add x5 ; sub x6,x5,x1 ; or x8,x5,x0
    step(1, 2, 5, 1, 0);
    step(5, 1, 6, 1, 0);
    begin_cyc(1'b1, 5, 0, 8, 1, 0, 0);
    chk("b2b_mem", 32'(fa), 2);
    end_cyc();
    begin_cyc(1'b1, 0, 0, 0, 0, 0, 0);
    chk("b2b_wb", 32'(fa), 1);
    end_cyc();

    // Double hit on x7, then the same with x0
    step(0, 0, 7, 1, 0);
    step(0, 0, 7, 1, 0);
    step(1, 7, 9, 1, 0);
    begin_cyc(1'b1, 0, 0, 0, 0, 0, 0);
    chk("dbl_m_prio", 32'(fb), 2);
    end_cyc();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 9, 1, 0);
    begin_cyc(1'b1, 0, 0, 0, 0, 0, 0);
    chk("dbl_x0", 32'(fb), 0);
    end_cyc();

    // Load-use: lw x3 ; add x4,x3,x2 (held one cycle in D)
    step(1, 0, 3, 1, 1);
    begin_cyc(1'b1, 3, 2, 4, 1, 0, 0);
    chk("lu_stall_f", 32'(sf), 1); chk("lu_flush_e", 32'(fe), 1); chk("lu_cnt0", 32'(cnt), 0);
    end_cyc();
    begin_cyc(1'b1, 3, 2, 4, 1, 0, 0);
    chk("lu_released", 32'(sd), 0); chk("lu_cnt1", 32'(cnt), 1);
    end_cyc();
    begin_cyc(1'b1, 0, 0, 0, 0, 0, 0);
    chk("lu_fwd_wb", 32'(fa), 1);
    end_cyc();

    // Branch resolving while a load-use pair is visible
    step(1, 0, 9, 1, 1);
    begin_cyc(1'b1, 9, 0, 4, 1, 0, 1);
    chk("br_stall", 32'(sd), 0); chk("br_flush_d", 32'(fd), 1); chk("br_flush_e", 32'(fe), 1);
    end_cyc();
    begin_cyc(1'b1, 0, 0, 0, 0, 0, 0);
    chk("br_cnt", 32'(cnt), 1);
    end_cyc();

    // Reset with writers in E/M/W and a load in E
    step(0, 0, 7, 1, 0);
    step(0, 0, 7, 1, 0);
    step(0, 0, 7, 1, 1);
    begin_cyc(1'b0, 7, 7, 1, 1, 0, 0); end_cyc();
    begin_cyc(1'b1, 7, 7, 1, 1, 0, 0);
    chk("rm_fwd_a", 32'(fa), 0); chk("rm_fwd_b", 32'(fb), 0);
    chk("rm_cnt", 32'(cnt), 0); chk("rm_stall", 32'(sd), 0);
    end_cyc();

    // Five load-use stalls on the 2-bit counter instance
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 3, 1, 1);
      step(3, 0, 4, 1, 0);
      begin_cyc(1'b1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("sat_%0d", k), 32'(cnt2), (k < 2) ? k + 1 : 3);
      end_cyc();
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bit l;
      l = ($urandom_range(0, 2) == 0);
      begin_cyc(($urandom_range(0, 39) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), l || ($urandom_range(0, 1) == 1), l,
                ($urandom_range(0, 7) == 0));
      end_cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
